// File: rtl/niu_pkg.sv
// Shared definitions for the NIU datapath blocks.
//   tx_arb_state_e : state encoding of the TX arbiter FSM
//   ABORT_TKEEP    : keep pattern of the single-lane abort beat
package niu_pkg;

  typedef logic [1:0] tx_arb_state_e;

  localparam tx_arb_state_e StIdle      = 2'd0;
  localparam tx_arb_state_e StXfer      = 2'd1;
  localparam tx_arb_state_e StAbortEmit = 2'd2;
  localparam tx_arb_state_e StDrain     = 2'd3;

  localparam logic [7:0] ABORT_TKEEP = 8'h01;

endpackage

// File: rtl/niu_rr_pick.sv
// Combinational rotate-priority encoder.
//   req    : request vector, one bit per port
//   rr_ptr : highest-priority port this cycle
//   hit    : at least one request is set
//   idx    : first requesting port at or after rr_ptr, wrapping modulo NUM_PORTS
module niu_rr_pick #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx
);

  // Walk from the lowest priority upward so the nearest requester to rr_ptr wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        hit = 1'b1;
        idx = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/niu_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 10G MAC TX AXI-Stream.
// A grant is held from the first beat of a frame through its tlast beat. If the
// granted source starves mid-frame for STALL_TIMEOUT cycles, a one-beat abort
// (tuser=1, tlast=1) is sent downstream and the rest of the frame is drained.
//   clk156, reset          : clock, asynchronous active-high reset
//   s_axis_*               : NUM_PORTS packed requester streams
//   m_axis_*               : merged stream towards the TX FIFO/MAC
//   grant_idx, busy        : current/last granted port, FSM not idle
//   pkt_cnt, abort_cnt     : completed and aborted frame counters (wrapping)
module niu_tx_arbiter
  import niu_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned KEEP_W        = 8,
  parameter int unsigned STALL_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 32,
  localparam int unsigned IDX_W        = $clog2(NUM_PORTS)
) (
  input  logic                        clk156,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [KEEP_W-1:0]           m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_cnt,
  output logic [CNT_W-1:0]            abort_cnt
);

  localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

  tx_arb_state_e      state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   abort_cnt_q, abort_cnt_d;

  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;

  logic               g_valid, g_last;
  logic [DATA_W-1:0]  g_data;
  logic [KEEP_W-1:0]  g_keep;

  niu_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req   (s_axis_tvalid),
    .rr_ptr(rr_ptr_q),
    .hit   (pick_hit),
    .idx   (pick_idx)
  );

  // View of the granted source.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_keep  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == IDX_W'(p)) begin
        g_valid = s_axis_tvalid[p];
        g_last  = s_axis_tlast[p];
        g_data  = s_axis_tdata[p*DATA_W +: DATA_W];
        g_keep  = s_axis_tkeep[p*KEEP_W +: KEEP_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    stall_d     = stall_q;
    pkt_cnt_d   = pkt_cnt_q;
    abort_cnt_d = abort_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_hit) begin
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_d  = StXfer;
        end
      end
      StXfer: begin
        if (g_valid) begin
          // Valid with no ready is MAC backpressure: stall count holds.
          if (m_axis_tready) begin
            stall_d = '0;
            if (g_last) begin
              pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
              state_d   = StIdle;
            end
          end
        end else if (stall_q == STALL_LAST) begin
          stall_d = '0;
          state_d = StAbortEmit;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      StAbortEmit: begin
        if (m_axis_tready) begin
          abort_cnt_d = abort_cnt_q + CNT_W'(1);
          state_d     = StDrain;
        end
      end
      StDrain: begin
        // Source ready is forced high here, so a valid tlast beat is consumed.
        if (g_valid && g_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    unique case (state_q)
      StXfer: begin
        s_axis_tready[grant_q] = m_axis_tready;
        m_axis_tdata           = g_data;
        m_axis_tkeep           = g_keep;
        m_axis_tvalid          = g_valid;
        m_axis_tlast           = g_last;
      end
      StAbortEmit: begin
        m_axis_tkeep  = KEEP_W'(ABORT_TKEEP);
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
      end
      StDrain: s_axis_tready[grant_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      stall_q     <= '0;
      pkt_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      stall_q     <= stall_d;
      pkt_cnt_q   <= pkt_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != StIdle);
  assign pkt_cnt   = pkt_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_niu_tx_arbiter.sv
// Self-checking bench for niu_tx_arbiter: table-driven arbitration order,
// hand sequences for stall abort, backpressure, async reset and counter wrap,
// and a randomized run checked against a cycle-level model of the arbitration rules.
module tb_niu_tx_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TO = 64;
  localparam int CW = 32;

  logic             clk156 = 1'b0;
  logic             reset  = 1'b0;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid, m_tlast, m_tuser;
  logic             m_tready = 1'b0;
  logic [1:0]       grant_idx;
  logic             busy;
  logic [CW-1:0]    pkt_cnt, abort_cnt;

  niu_tx_arbiter #(
    .NUM_PORTS    (NP),
    .DATA_W       (DW),
    .KEEP_W       (KW),
    .STALL_TIMEOUT(TO),
    .CNT_W        (CW)
  ) dut (
    .clk156       (clk156),
    .reset        (reset),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .m_axis_tready(m_tready),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .pkt_cnt      (pkt_cnt),
    .abort_cnt    (abort_cnt)
  );

  always #5 clk156 = ~clk156;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    int            cyc;
  } mbeat_t;

  typedef struct {
    bit             rst;
    logic [NP-1:0]  mask;
    int             len;
    int             n;
    logic [3:0][1:0] order;
  } vec_t;

  beat_t  src_q[NP][$];
  int     gap_plan[NP][$];
  int     stall_left[NP];
  mbeat_t mcap[$];
  int     gs_port[$];
  int     gs_cyc[$];
  vec_t   tbl[6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_mode = 1'b0;
  bit mon_en    = 1'b0;
  bit prev_busy = 1'b0;
  logic [NP-1:0] sfire;
  bit mfire;

  // Reference model state: arbitration pointer, grant and frame count.
  bit            mdl_busy;
  int            mdl_ptr;
  int            mdl_grant;
  logic [CW-1:0] mdl_pkts;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int p, input int tag, input int k);
    return {8'(p), 8'(tag), 16'hA5C3, 32'(k)};
  endfunction

  task automatic add_frame(input int p, input int len, input int tag);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = beat_data(p, tag, k);
      b.keep = (k == len - 1) ? 8'h3F : 8'hFF;
      b.last = (k == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic add_rand_frame(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = (k == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.last = (k == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (stall_left[p] == 0 && src_q[p].size() > 0) begin
        s_tvalid[p]          = 1'b1;
        s_tdata[p*DW +: DW]  = src_q[p][0].data;
        s_tkeep[p*KW +: KW]  = src_q[p][0].keep;
        s_tlast[p]           = src_q[p][0].last;
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tdata[p*DW +: DW]  = '0;
        s_tkeep[p*KW +: KW]  = '0;
        s_tlast[p]           = 1'b0;
      end
      if (stall_left[p] > 0) stall_left[p]--;
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_ptr   = 0;
    mdl_grant = 0;
    mdl_pkts  = '0;
    prev_busy = 1'b0;
  endtask

  // Per-cycle comparison against the arbitration rules (no abort expected here).
  task automatic monitor();
    logic [NP-1:0] exp_rdy;
    int pick;
    int c;
    check("busy", busy, mdl_busy);
    check("pkt_cnt", pkt_cnt, mdl_pkts);
    check("abort_cnt_zero", abort_cnt, 0);
    if (mdl_busy) begin
      exp_rdy = m_tready ? (NP'(1) << mdl_grant) : '0;
      check("grant_idx", grant_idx, mdl_grant);
      check("s_tready", s_tready, exp_rdy);
      check("m_tvalid", m_tvalid, s_tvalid[mdl_grant]);
      if (mfire) begin
        if (src_q[mdl_grant].size() == 0) begin
          check("beat_source_present", 0, 1);
        end else begin
          check("m_tdata", m_tdata, src_q[mdl_grant][0].data);
          check("m_tkeep", m_tkeep, src_q[mdl_grant][0].keep);
          check("m_tlast", m_tlast, src_q[mdl_grant][0].last);
          check("m_tuser", m_tuser, 0);
          if (src_q[mdl_grant][0].last) begin
            mdl_pkts++;
            mdl_busy = 1'b0;
          end
        end
      end
    end else begin
      check("s_tready_idle", s_tready, 0);
      check("m_tvalid_idle", m_tvalid, 0);
      pick = -1;
      for (int i = NP - 1; i >= 0; i--) begin
        c = (mdl_ptr + i) % NP;
        if (s_tvalid[c]) pick = c;
      end
      if (pick >= 0) begin
        mdl_busy  = 1'b1;
        mdl_grant = pick;
        mdl_ptr   = (pick + 1) % NP;
      end
    end
  endtask

  task automatic step();
    mbeat_t mb;
    @(negedge clk156);
    sfire = s_tvalid & s_tready;
    mfire = m_tvalid & m_tready;
    if (mfire) begin
      mb.data = m_tdata;
      mb.keep = m_tkeep;
      mb.last = m_tlast;
      mb.user = m_tuser;
      mb.cyc  = cyc;
      mcap.push_back(mb);
    end
    if (busy && !prev_busy) begin
      gs_port.push_back(int'(grant_idx));
      gs_cyc.push_back(cyc);
    end
    prev_busy = busy;
    if (mon_en) monitor();
    cyc++;
    @(posedge clk156);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (sfire[p]) begin
        if (src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (gap_plan[p].size() > 0) stall_left[p] = gap_plan[p].pop_front();
        else if (rand_mode && $urandom_range(0, 2) == 0) stall_left[p] = $urandom_range(1, 8);
      end
    end
    if (rand_mode) m_tready = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  task automatic run_until_idle(input int max, input string name);
    bit done = 1'b0;
    int n = 0;
    while (!done && n < max) begin
      step();
      n++;
      if (all_empty() && !prev_busy) done = 1'b1;
    end
    check(name, done, 1);
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      gap_plan[p].delete();
      stall_left[p] = 0;
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_sources();
    model_reset();
    repeat (2) @(posedge clk156);
    @(negedge clk156);
    reset = 1'b0;
    @(posedge clk156);
    #1;
  endtask

  task automatic set_vec(input int i, input bit rst, input logic [NP-1:0] mask, input int len,
                         input int n, input logic [1:0] o0, input logic [1:0] o1,
                         input logic [1:0] o2, input logic [1:0] o3);
    tbl[i].rst   = rst;
    tbl[i].mask  = mask;
    tbl[i].len   = len;
    tbl[i].n     = n;
    tbl[i].order = {o3, o2, o1, o0};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_pkts;
    int t0;
    bit stable;
    logic [DW-1:0] held;
    int n;

    // Grant order, beat timing and frame counts from a common start.
    set_vec(0, 1'b1, 4'b1111, 2, 4, 2'd0, 2'd1, 2'd2, 2'd3);
    set_vec(1, 1'b0, 4'b1001, 2, 2, 2'd0, 2'd3, 2'd0, 2'd0);
    set_vec(2, 1'b1, 4'b1010, 2, 2, 2'd1, 2'd3, 2'd0, 2'd0);
    set_vec(3, 1'b0, 4'b0101, 1, 2, 2'd0, 2'd2, 2'd0, 2'd0);
    set_vec(4, 1'b0, 4'b0110, 3, 2, 2'd1, 2'd2, 2'd0, 2'd0);
    set_vec(5, 1'b1, 4'b0001, 3, 1, 2'd0, 2'd0, 2'd0, 2'd0);

    #2;
    reset = 1'b1;
    clear_sources();
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_abort_cnt", abort_cnt, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_ctrl", {m_tvalid, m_tlast, m_tuser}, 0);
    check("rst_m_data", m_tdata, 0);
    check("rst_m_keep", m_tkeep, 0);
    do_reset();

    // Table-driven arbitration.
    mon_en   = 1'b1;
    m_tready = 1'b1;
    exp_pkts = 0;
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].rst) begin
        do_reset();
        exp_pkts = 0;
      end
      gs_port.delete();
      gs_cyc.delete();
      mcap.delete();
      cyc = 0;
      for (int p = 0; p < NP; p++) if (tbl[r].mask[p]) add_frame(p, tbl[r].len, r);
      drive();
      run_until_idle(100, $sformatf("tbl%0d_done", r));
      exp_pkts += tbl[r].n;
      check($sformatf("tbl%0d_ngrants", r), gs_port.size(), tbl[r].n);
      for (int i = 0; i < tbl[r].n && i < gs_port.size(); i++) begin
        check($sformatf("tbl%0d_order%0d", r, i), gs_port[i], tbl[r].order[i]);
        if (i == 0) check($sformatf("tbl%0d_first_cyc", r), gs_cyc[0], 1);
        else check($sformatf("tbl%0d_gap%0d", r, i), gs_cyc[i] - gs_cyc[i-1], tbl[r].len + 1);
      end
      check($sformatf("tbl%0d_nbeats", r), mcap.size(), tbl[r].n * tbl[r].len);
      check($sformatf("tbl%0d_pkt_cnt", r), pkt_cnt, exp_pkts);
    end

    // MAC backpressure for 200 cycles must not trigger an abort.
    do_reset();
    m_tready = 1'b0;
    add_frame(1, 2, 40);
    drive();
    n = 0;
    while (!prev_busy && n < 5) begin step(); n++; end
    check("bp_granted", prev_busy, 1);
    held   = m_tdata;
    stable = 1'b1;
    repeat (200) begin
      step();
      if (m_tdata !== held || m_tvalid !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_data", held, beat_data(1, 40, 0));
    check("bp_abort_cnt", abort_cnt, 0);
    m_tready = 1'b1;
    run_until_idle(20, "bp_done");
    check("bp_pkt_cnt", pkt_cnt, 1);

    // A 63-cycle source gap is one short of the timeout.
    mcap.delete();
    add_frame(0, 2, 41);
    gap_plan[0].push_back(TO - 1);
    drive();
    run_until_idle(200, "gap63_done");
    check("gap63_abort_cnt", abort_cnt, 0);
    check("gap63_pkt_cnt", pkt_cnt, 2);
    check("gap63_nbeats", mcap.size(), 2);
    if (mcap.size() == 2) check("gap63_spacing", mcap[1].cyc - mcap[0].cyc, TO);

    // Stall abort: 64 idle cycles after beat 1, then the tail is drained.
    do_reset();
    mon_en = 1'b0;
    mcap.delete();
    cyc = 0;
    add_frame(2, 3, 50);
    gap_plan[2].push_back(TO);
    drive();
    run_until_idle(300, "abort_done");
    check("abort_nbeats", mcap.size(), 2);
    if (mcap.size() >= 2) begin
      check("abort_b0_data", mcap[0].data, beat_data(2, 50, 0));
      check("abort_b0_user", {mcap[0].last, mcap[0].user}, 0);
      check("abort_data", mcap[1].data, 0);
      check("abort_keep", mcap[1].keep, 8'h01);
      check("abort_last_user", {mcap[1].last, mcap[1].user}, 2'b11);
      check("abort_latency", mcap[1].cyc - mcap[0].cyc, TO + 1);
    end
    check("abort_cnt1", abort_cnt, 1);
    check("abort_pkt_cnt", pkt_cnt, 0);

    // The abort beat must hold while the MAC is not ready.
    mcap.delete();
    add_frame(0, 2, 51);
    gap_plan[0].push_back(TO);
    drive();
    n = 0;
    while (mcap.size() < 1 && n < 10) begin step(); n++; end
    m_tready = 1'b0;
    repeat (TO + 6) step();
    check("abort_hold_ctrl", {m_tvalid, m_tlast, m_tuser}, 3'b111);
    check("abort_hold_keep", m_tkeep, 8'h01);
    check("abort_hold_rdy", s_tready, 0);
    check("abort_hold_cnt", abort_cnt, 1);
    m_tready = 1'b1;
    run_until_idle(50, "abort2_done");
    check("abort_cnt2", abort_cnt, 2);
    check("abort2_nbeats", mcap.size(), 2);

    // Asynchronous reset in the middle of a frame on port 1.
    do_reset();
    mon_en = 1'b1;
    add_frame(0, 1, 60);
    drive();
    run_until_idle(20, "prerst_done");
    mcap.delete();
    add_frame(1, 4, 61);
    drive();
    n = 0;
    while (mcap.size() < 2 && n < 10) begin step(); n++; end
    check("prerst_m_tvalid", m_tvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_s_tready", s_tready, 0);
    check("arst_m_ctrl", {m_tvalid, m_tlast, m_tuser}, 0);
    check("arst_m_data", m_tdata, 0);
    check("arst_busy", busy, 0);
    check("arst_grant", grant_idx, 0);
    check("arst_pkt_cnt", pkt_cnt, 0);
    clear_sources();
    model_reset();
    @(negedge clk156);
    reset = 1'b0;
    @(posedge clk156);
    #1;
    gs_port.delete();
    add_frame(3, 1, 62);
    add_frame(1, 1, 63);
    drive();
    run_until_idle(20, "postrst_done");
    check("postrst_ngrants", gs_port.size(), 2);
    if (gs_port.size() > 0) check("postrst_first_grant", gs_port[0], 1);
    check("postrst_pkt_cnt", pkt_cnt, 2);

    // Frame counter wrap from all-ones.
    force dut.pkt_cnt_q = {CW{1'b1}};
    @(posedge clk156);
    #1;
    release dut.pkt_cnt_q;
    mdl_pkts = {CW{1'b1}};
    check("wrap_preset", pkt_cnt, 32'hFFFF_FFFF);
    add_frame(2, 2, 70);
    drive();
    run_until_idle(20, "wrap1_done");
    check("wrap_to_0", pkt_cnt, 0);
    add_frame(0, 1, 71);
    drive();
    run_until_idle(20, "wrap2_done");
    check("wrap_to_1", pkt_cnt, 1);

    // Randomized traffic with source gaps and MAC backpressure.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) add_rand_frame($urandom_range(0, NP - 1), $urandom_range(1, 6));
    for (int p = 0; p < NP; p++) stall_left[p] = $urandom_range(0, 5);
    drive();
    run_until_idle(20000, "rand_done");
    rand_mode = 1'b0;
    check("rand_pkt_cnt", pkt_cnt, 40);
    check("rand_abort_cnt", abort_cnt, 0);

    t0 = n_checks;
    if (t0 == 0) n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
